traffic_signal_ctrl: RTL and testbench
======================================

Name: traffic_signal_ctrl

Overview:
- Parametrised successor to the two-road Signals controller: a highway / country-road intersection sequencer.
- Adds three-aspect lamps (red/yellow/green), programmable phase durations, a minimum highway green, a maximum country green, an all-red clearance interval, and an emergency preempt.
- Sits between the road sensor and the lamp drivers; single clock domain.

Parameters:
- HWY_MIN_GREEN, 8: minimum highway-green cycles before a country request is honoured (>=1).
- YELLOW_TIME, 3: cycles in each yellow phase (>=1).
- ALL_RED_TIME, 1: cycles in each all-red clearance phase (>=1).
- CTRY_MAX_GREEN, 6: maximum country-green cycles (>=1).
- CNT_W, 4: phase timer width. Must hold max(all durations)-1; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on clk rising edge.
- S  in  1  country-road vehicle sensor, 1 = vehicle waiting.
- set  in  1  emergency preempt, 1 = force and hold highway green.
- SH  out  3  highway lamps {red,yellow,green}, one-hot.
- SC  out  3  country lamps {red,yellow,green}, one-hot.
- phase  out  3  state code: HG=0, HY=1, AR1=2, CG=3, CY=4, AR2=5.

Behaviour:
- State register and a CNT_W-bit timer. The timer clears to 0 on every state change, otherwise increments; in HG it saturates at HWY_MIN_GREEN-1.
- Outputs are a combinational decode of the state register, valid in the same cycle as the state:
  - HG: SH=001, SC=100.
  - HY: SH=010, SC=100.
  - AR1, AR2: SH=100, SC=100.
  - CG: SH=100, SC=001.
  - CY: SH=100, SC=010.
  - Unused codes 6 and 7 decode as all-red and go to AR2 on the next cycle.
- Reset (reset==0 at an edge): next state HG, timer 0, SH=001, SC=100, phase=0. Reset has priority over everything and aborts any phase mid-count.
- Transitions, evaluated each edge; precedence is reset > set > S:
  - HG -> HY when timer==HWY_MIN_GREEN-1 and S==1 and set==0. Otherwise stay in HG; S arriving after min green exits on the next edge.
  - HY -> AR1 when timer==YELLOW_TIME-1.
  - AR1 at timer==ALL_RED_TIME-1: -> HG if set==1, else -> CG.
  - CG -> CY when S==0, or set==1, or timer==CTRY_MAX_GREEN-1. CG always lasts at least 1 cycle.
  - CY -> AR2 when timer==YELLOW_TIME-1.
  - AR2 -> HG when timer==ALL_RED_TIME-1.
- Safety invariants, asserted in the bench:
  - SH and SC are never both non-red.
  - A green lamp never goes directly to red or to the other road's green.
  - Every yellow lasts exactly YELLOW_TIME cycles; set does not shorten yellow or all-red.
- set held high permanently: after any in-flight sequence drains, the controller stays in HG regardless of S.
- S and set are synchronous inputs; no internal debouncing or synchronisation.

Test Plan:
- Reset low for 2 cycles, then S=0, set=0 for 50 cycles -> SH=001, SC=100, phase=0 on every cycle.
- S=1 held from cycle 0 after reset release (defaults) -> HG 0–7, HY 8–10, AR1 11, CG 12–17 (max green), CY 18–20, AR2 21, HG 22–29, HY at 30.
- S=1 cycles 0–13, S=0 from 14 -> CG 12–14, CY 15–17, AR2 18, HG from 19 with the timer restarted. S=1 first asserted at cycle 20 (HG in progress) -> HY at 8 cycles after HG entry, i.e. cycle 27.
- Preempt checks:
  - S=1, set pulsed at cycle 13 (CG) -> CY 14–16, AR2 17, HG 18.
  - S=1, set high at cycle 11 (AR1) -> HG at 12, no CG.
  - set and S both held high from cycle 0 -> HG for the entire run.
- reset low for one cycle during CY (cycle 19) -> HG at 20 with SH=001, SC=100. With S=1 held, HY at 28, confirming the full min-green restarts.
- Override HWY_MIN_GREEN=2, YELLOW_TIME=1, ALL_RED_TIME=2, CTRY_MAX_GREEN=1, CNT_W=2, S=1 -> HG 0–1, HY 2, AR1 3–4, CG 5, CY 6, AR2 7–8, HG 9. One-hot and invariant checks run throughout.

Source files
------------

// File: rtl/traffic_signal_ctrl.sv
// Highway / country-road intersection sequencer with three-aspect lamps,
// programmable phase durations, minimum highway green, maximum country green,
// all-red clearance and an emergency preempt that forces highway green.
module traffic_signal_ctrl #(
    parameter int HWY_MIN_GREEN  = 8,
    parameter int YELLOW_TIME    = 3,
    parameter int ALL_RED_TIME   = 1,
    parameter int CTRY_MAX_GREEN = 6,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       S,
    input  logic       set,
    output logic [2:0] SH,
    output logic [2:0] SC,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam int MAX_AB   = (HWY_MIN_GREEN > YELLOW_TIME) ? HWY_MIN_GREEN : YELLOW_TIME;
    localparam int MAX_CD   = (ALL_RED_TIME > CTRY_MAX_GREEN) ? ALL_RED_TIME : CTRY_MAX_GREEN;
    localparam int MAX_DUR  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;

    localparam logic [CNT_W-1:0] HG_LAST  = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] CG_LAST  = CNT_W'(CTRY_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Refuse to build when a duration is zero or the timer cannot reach the longest terminal count
    if ((HWY_MIN_GREEN < 1) || (YELLOW_TIME < 1) || (ALL_RED_TIME < 1) || (CTRY_MAX_GREEN < 1)) begin : g_dur_check
        $error("traffic_signal_ctrl: every phase duration must be at least 1");
    end
    if ((MAX_DUR - 1) >= (1 << CNT_W)) begin : g_cnt_w_check
        $error("traffic_signal_ctrl: CNT_W too narrow for the longest phase duration");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;

    // State register and phase timer: timer restarts on any state change, holds once min green is met
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= HG;
            timer <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= '0;
            end else if ((state == HG) && (timer == HG_LAST)) begin
                timer <= timer;
            end else begin
                timer <= timer + CNT_ONE;
            end
        end
    end

    // Next-state selection and lamp decode; preempt outranks the country sensor everywhere
    always_comb begin
        state_next = state;
        SH         = LAMP_RED;
        SC         = LAMP_RED;
        phase      = state;
        case (state)
            HG: begin
                SH = LAMP_GREEN;
                if ((timer == HG_LAST) && S && !set) begin
                    state_next = HY;
                end
            end
            HY: begin
                SH = LAMP_YELLOW;
                if (timer == YEL_LAST) begin
                    state_next = AR1;
                end
            end
            AR1: begin
                if (timer == AR_LAST) begin
                    state_next = set ? HG : CG;
                end
            end
            CG: begin
                SC = LAMP_GREEN;
                if (!S || set || (timer == CG_LAST)) begin
                    state_next = CY;
                end
            end
            CY: begin
                SC = LAMP_YELLOW;
                if (timer == YEL_LAST) begin
                    state_next = AR2;
                end
            end
            AR2: begin
                if (timer == AR_LAST) begin
                    state_next = HG;
                end
            end
            default: begin
                state_next = AR2;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_signal_ctrl.sv
// Self-checking bench for traffic_signal_ctrl: directed run-length vector table,
// randomized stimulus against a behavioural model, and safety invariants on two
// instances (default and a short-timing parameter override).
module tb_traffic_signal_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       S;
    logic       set;
    logic [2:0] sh_d, sc_d, ph_d;
    logic [2:0] sh_s, sc_s, ph_s;

    traffic_signal_ctrl dut_def (
        .clk   (clk),
        .reset (reset),
        .S     (S),
        .set   (set),
        .SH    (sh_d),
        .SC    (sc_d),
        .phase (ph_d)
    );

    traffic_signal_ctrl #(
        .HWY_MIN_GREEN  (2),
        .YELLOW_TIME    (1),
        .ALL_RED_TIME   (2),
        .CTRY_MAX_GREEN (1),
        .CNT_W          (2)
    ) dut_small (
        .clk   (clk),
        .reset (reset),
        .S     (S),
        .set   (set),
        .SH    (sh_s),
        .SC    (sc_s),
        .phase (ph_s)
    );

    int checks   = 0;
    int failures = 0;

    // Phase durations per instance: index 0 = default, 1 = short override
    int p_min  [2] = '{8, 2};
    int p_yel  [2] = '{3, 1};
    int p_ar   [2] = '{1, 2};
    int p_cmax [2] = '{6, 1};

    // Behavioural model: current phase and cycles already spent in it (unbounded)
    int m_ph [2];
    int m_el [2];

    // Invariant tracking
    logic [2:0] prev_sh [2];
    logic [2:0] prev_sc [2];
    int         ycnt_h  [2];
    int         ycnt_c  [2];
    bit         prev_valid = 1'b0;
    bit         last_rst   = 1'b0;

    typedef struct {
        int dsel;
        bit rn;
        bit s;
        bit st;
        int n;
        int exp_ph;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [2:0] lamp_sh(int ph);
        case (ph)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] lamp_sc(int ph);
        case (ph)
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic compareValue(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Phase rules as elapsed-time thresholds; a phase ends when its elapsed count reaches its duration
    task automatic model_step(int d, bit rn, bit s, bit st);
        int nxt;
        bool_done: begin end
        nxt = m_ph[d];
        if (!rn) begin
            nxt = 0;
        end else begin
            case (m_ph[d])
                0: if (m_el[d] + 1 >= p_min[d] && s && !st) nxt = 1;
                1: if (m_el[d] + 1 >= p_yel[d]) nxt = 2;
                2: if (m_el[d] + 1 >= p_ar[d]) nxt = st ? 0 : 3;
                3: if (!s || st || m_el[d] + 1 >= p_cmax[d]) nxt = 4;
                4: if (m_el[d] + 1 >= p_yel[d]) nxt = 5;
                default: if (m_el[d] + 1 >= p_ar[d]) nxt = 0;
            endcase
        end
        if (!rn || nxt != m_ph[d]) begin
            m_ph[d] = nxt;
            m_el[d] = 0;
        end else begin
            m_el[d] = m_el[d] + 1;
        end
    endtask

    task automatic checkOutput(int dsel, int exp_ph);
        logic [2:0] a_ph [2];
        logic [2:0] a_sh [2];
        logic [2:0] a_sc [2];
        a_ph = '{ph_d, ph_s};
        a_sh = '{sh_d, sh_s};
        a_sc = '{sc_d, sc_s};
        if (exp_ph >= 0) begin
            compareValue($sformatf("vec_phase[d%0d]", dsel), int'(a_ph[dsel]), exp_ph);
            compareValue($sformatf("vec_SH[d%0d]", dsel), int'(a_sh[dsel]), int'(lamp_sh(exp_ph)));
            compareValue($sformatf("vec_SC[d%0d]", dsel), int'(a_sc[dsel]), int'(lamp_sc(exp_ph)));
        end
        for (int d = 0; d < 2; d++) begin
            compareValue($sformatf("model_phase[d%0d]", d), int'(a_ph[d]), m_ph[d]);
            compareValue($sformatf("model_SH[d%0d]", d), int'(a_sh[d]), int'(lamp_sh(m_ph[d])));
            compareValue($sformatf("model_SC[d%0d]", d), int'(a_sc[d]), int'(lamp_sc(m_ph[d])));
            compareValue($sformatf("onehot[d%0d]", d),
                         int'($onehot(a_sh[d]) && $onehot(a_sc[d])), 1);
            compareValue($sformatf("both_nonred[d%0d]", d),
                         int'((a_sh[d] != 3'b100) && (a_sc[d] != 3'b100)), 0);
            if (prev_valid && last_rst) begin
                if (prev_sh[d] == 3'b001)
                    compareValue($sformatf("hwy_green_exit[d%0d]", d),
                                 int'((a_sh[d] == 3'b001) || (a_sh[d] == 3'b010)), 1);
                if (prev_sc[d] == 3'b001)
                    compareValue($sformatf("ctry_green_exit[d%0d]", d),
                                 int'((a_sc[d] == 3'b001) || (a_sc[d] == 3'b010)), 1);
            end
            if (!last_rst) begin
                ycnt_h[d] = 0;
                ycnt_c[d] = 0;
            end else begin
                if (a_sh[d] == 3'b010) ycnt_h[d]++;
                else if (ycnt_h[d] > 0) begin
                    compareValue($sformatf("hwy_yellow_len[d%0d]", d), ycnt_h[d], p_yel[d]);
                    ycnt_h[d] = 0;
                end
                if (a_sc[d] == 3'b010) ycnt_c[d]++;
                else if (ycnt_c[d] > 0) begin
                    compareValue($sformatf("ctry_yellow_len[d%0d]", d), ycnt_c[d], p_yel[d]);
                    ycnt_c[d] = 0;
                end
            end
            prev_sh[d] = a_sh[d];
            prev_sc[d] = a_sc[d];
        end
        prev_valid = 1'b1;
    endtask

    // One cycle: drive inputs, check the current state, take the edge, advance the model
    task automatic applyStimulus(bit rn, bit s, bit st, int dsel, int exp_ph);
        reset = rn;
        S     = s;
        set   = st;
        checkOutput(dsel, exp_ph);
        @(posedge clk);
        model_step(0, rn, s, st);
        model_step(1, rn, s, st);
        last_rst = rn;
        #1;
    endtask

    function automatic void add(int dsel, bit rn, bit s, bit st, int n, int exp_ph);
        vec_t v;
        v.dsel = dsel; v.rn = rn; v.s = s; v.st = st; v.n = n; v.exp_ph = exp_ph;
        vecs.push_back(v);
    endfunction

    function automatic void add_reset(int dsel);
        add(dsel, 1'b0, 1'b0, 1'b0, 2, -1);
    endfunction

    initial begin
        // Idle: no traffic, highway green throughout
        add_reset(0);
        add(0, 1, 0, 0, 50, 0);
        // Full cycle with S held, country green runs to its maximum
        add_reset(0);
        add(0, 1, 1, 0, 8, 0); add(0, 1, 1, 0, 3, 1); add(0, 1, 1, 0, 1, 2);
        add(0, 1, 1, 0, 6, 3); add(0, 1, 1, 0, 3, 4); add(0, 1, 1, 0, 1, 5);
        add(0, 1, 1, 0, 8, 0); add(0, 1, 1, 0, 1, 1);
        // S drops during country green, then returns mid highway green
        add_reset(0);
        add(0, 1, 1, 0, 8, 0); add(0, 1, 1, 0, 3, 1); add(0, 1, 1, 0, 1, 2);
        add(0, 1, 1, 0, 2, 3); add(0, 1, 0, 0, 1, 3); add(0, 1, 0, 0, 3, 4);
        add(0, 1, 0, 0, 1, 5); add(0, 1, 0, 0, 1, 0); add(0, 1, 1, 0, 7, 0);
        add(0, 1, 1, 0, 1, 1);
        // Preempt pulse during country green
        add_reset(0);
        add(0, 1, 1, 0, 8, 0); add(0, 1, 1, 0, 3, 1); add(0, 1, 1, 0, 1, 2);
        add(0, 1, 1, 0, 1, 3); add(0, 1, 1, 1, 1, 3); add(0, 1, 1, 0, 3, 4);
        add(0, 1, 1, 0, 1, 5); add(0, 1, 1, 0, 1, 0);
        // Preempt raised during first all-red: country green skipped
        add_reset(0);
        add(0, 1, 1, 0, 8, 0); add(0, 1, 1, 0, 3, 1); add(0, 1, 1, 1, 1, 2);
        add(0, 1, 1, 1, 6, 0);
        // Preempt and S both held: highway green forever
        add_reset(0);
        add(0, 1, 1, 1, 40, 0);
        // Reset pulse during country yellow restarts full min green
        add_reset(0);
        add(0, 1, 1, 0, 8, 0); add(0, 1, 1, 0, 3, 1); add(0, 1, 1, 0, 1, 2);
        add(0, 1, 1, 0, 6, 3); add(0, 1, 1, 0, 1, 4); add(0, 0, 1, 0, 1, 4);
        add(0, 1, 1, 0, 8, 0); add(0, 1, 1, 0, 1, 1);
        // Short-timing instance full sequence
        add_reset(1);
        add(1, 1, 1, 0, 2, 0); add(1, 1, 1, 0, 1, 1); add(1, 1, 1, 0, 2, 2);
        add(1, 1, 1, 0, 1, 3); add(1, 1, 1, 0, 1, 4); add(1, 1, 1, 0, 2, 5);
        add(1, 1, 1, 0, 1, 0);

        reset = 1'b0;
        S     = 1'b0;
        set   = 1'b0;
        repeat (2) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_ph[d]   = 0;
            m_el[d]   = 0;
            ycnt_h[d] = 0;
            ycnt_c[d] = 0;
        end
        last_rst = 1'b0;
        #1;

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                applyStimulus(vecs[i].rn, vecs[i].s, vecs[i].st, vecs[i].dsel, vecs[i].exp_ph);
            end
        end

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 149) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 24) == 0, 0, -1);
        end
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 1) != 0,
                          $urandom_range(0, 9) != 0, 0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
